lcd_disp_source: RTL



---
 rtl/lcd_disp_pkg.sv | 24 ++
 rtl/lcd_tick_gen.sv | 31 +++
 rtl/lcd_disp_source.sv | 103 ++++++++++
 3 files changed

// File: rtl/lcd_disp_pkg.sv
// Shared constants for the LCD display-slot source: slot indices and ASCII slot names.
// Latency: n/a (constants only).
// Backpressure: n/a.
package lcd_disp_pkg;

  localparam int unsigned NAME_W_DEF = 40;

  localparam logic [5:0] SLOT_INPUT = 6'd1;
  localparam logic [5:0] SLOT_COUNT = 6'd2;
  localparam logic [5:0] SLOT_SUM   = 6'd3;
  localparam logic [5:0] SLOT_MAX   = 6'd4;
  localparam logic [5:0] SLOT_TICKS = 6'd5;
  localparam logic [5:0] SLOT_DATA  = 6'd6;
  localparam int unsigned NUM_SLOTS = 6;

  // Five ASCII characters, first character in the MSB byte.
  localparam logic [39:0] NAME_INPUT = "INPUT";
  localparam logic [39:0] NAME_COUNT = "COUNT";
  localparam logic [39:0] NAME_SUM   = "SUM  ";
  localparam logic [39:0] NAME_MAX   = "MAX  ";
  localparam logic [39:0] NAME_TICKS = "TICKS";
  localparam logic [39:0] NAME_DATA  = "Data ";

endpackage

// File: rtl/lcd_tick_gen.sv
// Prescaler emitting a one-cycle tick every CLK_HZ clocks (first tick CLK_HZ-1 cycles after reset).
// Latency: tick_o is combinational from the prescaler register.
// Backpressure: none; free-running.
// Ports: clk, resetn (sync active-low), tick_o (high on the cycle the prescaler wraps).
module lcd_tick_gen #(
  parameter int unsigned CLK_HZ = 100000000
) (
  input  logic clk,
  input  logic resetn,
  output logic tick_o
);

  localparam int unsigned CW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick_o = (cnt_q == CW'(CLK_HZ - 1));
    cnt_d  = tick_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_disp_source.sv
// Display-slot source for lcd_module: keypad statistics, seconds counter and a constant, read by slot index.
// Latency: 1 cycle from display_number to display_valid/name/value (registered lookup).
// Backpressure: none; display_number may change every cycle.
// Ports: clk, resetn (sync active-low); display_number in; input_valid/input_value keypad events in;
//        clear pulse in; display_valid/display_name/display_value registered out.
module lcd_disp_source
  import lcd_disp_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter logic [31:0] INIT_VALUE = 32'd20241106,
  parameter int unsigned NAME_W     = NAME_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [5:0]        display_number,
  input  logic              input_valid,
  input  logic [31:0]       input_value,
  input  logic              clear,
  output logic              display_valid,
  output logic [NAME_W-1:0] display_name,
  output logic [31:0]       display_value
);

  logic        tick;
  logic        ev;
  logic        input_valid_q;
  logic [31:0] input_q, input_d;
  logic [31:0] count_q, count_d;
  logic [31:0] sum_q,   sum_d;
  logic [31:0] max_q,   max_d;
  logic [31:0] ticks_q, ticks_d;
  logic              valid_d;
  logic [NAME_W-1:0] name_d;
  logic [31:0]       value_d;

  lcd_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk    (clk),
    .resetn (resetn),
    .tick_o (tick)
  );

  always_comb begin
    // A level held high is one event; only the rising edge counts.
    ev      = input_valid & ~input_valid_q;
    input_d = input_q;
    count_d = count_q;
    sum_d   = sum_q;
    max_d   = max_q;
    // clear zeroes first so a coincident event lands on a clean slate.
    if (clear) begin
      input_d = '0;
      count_d = '0;
      sum_d   = '0;
      max_d   = '0;
    end
    if (ev) begin
      input_d = input_value;
      count_d = count_d + 32'd1;
      sum_d   = sum_d + input_value;
      max_d   = (input_value > max_d) ? input_value : max_d;
    end
    ticks_d = tick ? ticks_q + 32'd1 : ticks_q;

    // Lookup uses the current register contents, not the next-state values.
    valid_d = 1'b1;
    name_d  = '0;
    value_d = '0;
    case (display_number)
      SLOT_INPUT: begin name_d = NAME_W'(NAME_INPUT); value_d = input_q;    end
      SLOT_COUNT: begin name_d = NAME_W'(NAME_COUNT); value_d = count_q;    end
      SLOT_SUM:   begin name_d = NAME_W'(NAME_SUM);   value_d = sum_q;      end
      SLOT_MAX:   begin name_d = NAME_W'(NAME_MAX);   value_d = max_q;      end
      SLOT_TICKS: begin name_d = NAME_W'(NAME_TICKS); value_d = ticks_q;    end
      SLOT_DATA:  begin name_d = NAME_W'(NAME_DATA);  value_d = INIT_VALUE; end
      default:    valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      input_valid_q <= 1'b0;
      input_q       <= '0;
      count_q       <= '0;
      sum_q         <= '0;
      max_q         <= '0;
      ticks_q       <= '0;
      display_valid <= 1'b0;
      display_name  <= '0;
      display_value <= '0;
    end else begin
      input_valid_q <= input_valid;
      input_q       <= input_d;
      count_q       <= count_d;
      sum_q         <= sum_d;
      max_q         <= max_d;
      ticks_q       <= ticks_d;
      display_valid <= valid_d;
      display_name  <= name_d;
      display_value <= value_d;
    end
  end

endmodule
